// File: rtl/play_time_counter_if.sv
// Run/clear controls and BCD time digit bus shared by the player FSM,
// play_time_counter and the display decoders.
interface play_time_counter_if;
  logic       run;
  logic       clear;
  logic [5:0] sec_ones;
  logic [5:0] sec_tens;
  logic [5:0] min_ones;
  logic [5:0] min_tens;
  logic       sec_tick;
  logic       wrapped;

  modport master (
    output run, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, sec_tick, wrapped
  );

  modport slave (
    input  run, clear,
    output sec_ones, sec_tens, min_ones, min_tens, sec_tick, wrapped
  );
endinterface

// File: rtl/play_time_counter.sv
// Elapsed play time counter (MM:SS, 00:00..99:59) with BCD digit outputs.
// Define LEADING_ZERO_BLANK_EN to blank a leading zero in the minutes-tens digit.
module play_time_counter #(
  parameter int unsigned CLKS_PER_SEC = 50_000_000
) (
  input logic              clk,
  input logic              rst_n,
  play_time_counter_if.slave bus
);

  localparam int unsigned PW = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [3:0]    s1;
  logic [3:0]    s10;
  logic [3:0]    m1;
  logic [3:0]    m10;
  logic          tick;
  logic          wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      s1    <= '0;
      s10   <= '0;
      m1    <= '0;
      m10   <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (bus.clear) begin
      // clear wins over a coincident terminal count: no tick or wrap escapes
      presc <= '0;
      s1    <= '0;
      s10   <= '0;
      m1    <= '0;
      m10   <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (bus.run) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
          if (s1 == 4'd9) begin
            s1 <= '0;
            if (s10 == 4'd5) begin
              s10 <= '0;
              if (m1 == 4'd9) begin
                m1 <= '0;
                if (m10 == 4'd9) begin
                  m10  <= '0;
                  wrap <= 1'b1;
                end else begin
                  m10 <= m10 + 4'd1;
                end
              end else begin
                m1 <= m1 + 4'd1;
              end
            end else begin
              s10 <= s10 + 4'd1;
            end
          end else begin
            s1 <= s1 + 4'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign bus.sec_ones = {2'b00, s1};
  assign bus.sec_tens = {2'b00, s10};
  assign bus.min_ones = {2'b00, m1};
`ifdef LEADING_ZERO_BLANK_EN
  assign bus.min_tens = (m10 == 4'd0) ? 6'd63 : {2'b00, m10};
`else
  assign bus.min_tens = {2'b00, m10};
`endif
  assign bus.sec_tick = tick;
  assign bus.wrapped  = wrap;

endmodule
